multi_digit_led_driver: RTL and testbench
=========================================

MULTI_DIGIT_LED_DRIVER -- requirements
Module: multi_digit_led_driver

Interface
REQ-001 Clocking SHALL be: one clock; reset is asynchronous and active-low.
REQ-002 Parameter NUM_DIGITS, default 4, SHALL set the number of multiplexed digits (range 2..8).
REQ-003 Parameter DWELL_CYCLES, default 4, SHALL set the clk cycles each anode is driven per slot (>=1).
REQ-004 Parameter BLANK_CYCLES, default 1, SHALL set the all-anodes-off cycles preceding each dwell (>=1).
REQ-005 Parameter MSG_LEN, default 8, SHALL set the number of 4-bit characters in the message (>=NUM_DIGITS).
REQ-006 Parameter SCROLL_FRAMES, default 4, SHALL set the frames per scroll step (used only with SCROLL_EN).
REQ-007 Ports SHALL be:
  clk  in  1  system clock
  reset  in  1  asynchronous active-low reset
  enable  in  1  scan enable
  msg_data  in  4*MSG_LEN  message; char i = msg_data[4i+3:4i]
  msg_valid  in  1  message offered
  msg_ready  out  1  pending buffer empty
  an  out  NUM_DIGITS  anodes, active-low; an[NUM_DIGITS-1] = leftmost
  seg  out  7  segments, active-low; seg[6..0] = a..g
  frame_tick  out  1  one-cycle pulse at each frame start

Function
REQ-008 Each slot SHALL be BLANK_CYCLES with an all ones, then DWELL_CYCLES with exactly one an bit low; slots SHALL run leftmost (position p=0, an[NUM_DIGITS-1]) to rightmost (an[0]), then wrap to p=0.
REQ-009 Frame length SHALL be exactly NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles; frame_tick SHALL be high on the first blank cycle of slot p=0.
REQ-010 Position p SHALL display char index (scroll_pos+p) mod MSG_LEN of the active buffer, decoded as hex glyphs 0-9, A-F.
REQ-011 seg SHALL be registered and SHALL update only during blank cycles, never during a dwell cycle.
REQ-012 A transfer SHALL occur on a clk edge with msg_valid and msg_ready both high; msg_data SHALL be captured into the pending buffer and msg_ready SHALL drop on the next cycle.
REQ-013 On the frame_tick cycle a full pending buffer SHALL be copied to the active buffer, scroll_pos SHALL be cleared to 0, and msg_ready SHALL return high on the next cycle.
REQ-014 A transfer on the frame_tick cycle with an empty pending buffer SHALL be held in pending and committed at the following frame.
REQ-015 While enable is low, an SHALL be all ones, seg SHALL be all ones, and all counters SHALL hold; the handshake SHALL remain operational.
REQ-016 After enable rises, scanning SHALL resume from the held slot and cycle count.

Reset
REQ-017 While reset is low: an all ones, seg all ones, frame_tick 0, msg_ready 1, active and pending buffers all zeros, pending marked empty, scroll_pos 0.
REQ-018 The first cycle after reset release SHALL be blank cycle 0 of slot p=0, with frame_tick high if enable is high.
REQ-019 Reset asserted mid-frame or mid-handshake SHALL discard pending data and restart the frame.

Configuration
REQ-020 With macro LED_DRIVER_SCROLL_EN defined, scroll_pos SHALL increment modulo MSG_LEN on every SCROLL_FRAMES-th frame_tick.
REQ-021 Without LED_DRIVER_SCROLL_EN, scroll_pos SHALL be constant 0 and the scroll-frame counter SHALL not exist.

Structure
REQ-022 A shared package SHALL hold the hex glyph constants, the blank segment constant (7'b1111111), and the all-off anode value.
REQ-023 Glyph decoding SHALL be a combinational sub-module named seg_hex_decoder (4-bit char in, 7-bit active-low segments out).

Verification
REQ-024 The bench SHALL cover these scenarios with NUM_DIGITS=4, DWELL=4, BLANK=1, MSG_LEN=8:
  1. Reset release, enable=1 -> frame_tick every 20 cycles; an sequence 0111,1011,1101,1110, each low for 4 cycles after 1 blank cycle.
  2. Load chars 1,2,3,4 (char0=1) -> after the next frame_tick the digits read 1,2,3,4 left to right.
  3. Transfer then a second msg_valid before frame_tick -> msg_ready low, the second message is not taken, and it is accepted the cycle after commit.
  4. Transfer coincident with frame_tick -> display unchanged for that frame and updated at the next frame.
  5. enable low for 7 cycles mid-dwell -> an and seg all ones, and the slot resumes with the remaining dwell count.
  6. With LED_DRIVER_SCROLL_EN and SCROLL_FRAMES=2, message 0..7 -> leftmost digit shows 0,0,1,1,2,2..., and 7 wraps to 0.

Source files
------------

// File: rtl/multi_digit_led_driver_pkg.sv
// Shared constants for the multiplexed LED driver: active-low hex glyphs,
// blank segment pattern, all-off anode value and the scan phase type.
package multi_digit_led_driver_pkg;

    localparam logic [6:0] SEG_BLANK  = 7'b1111111;
    localparam logic [7:0] AN_ALL_OFF = 8'hFF;

    // seg[6..0] = a..g, active-low
    localparam logic [6:0] GLYPH_0 = 7'h01;
    localparam logic [6:0] GLYPH_1 = 7'h4F;
    localparam logic [6:0] GLYPH_2 = 7'h12;
    localparam logic [6:0] GLYPH_3 = 7'h06;
    localparam logic [6:0] GLYPH_4 = 7'h4C;
    localparam logic [6:0] GLYPH_5 = 7'h24;
    localparam logic [6:0] GLYPH_6 = 7'h20;
    localparam logic [6:0] GLYPH_7 = 7'h0F;
    localparam logic [6:0] GLYPH_8 = 7'h00;
    localparam logic [6:0] GLYPH_9 = 7'h04;
    localparam logic [6:0] GLYPH_A = 7'h08;
    localparam logic [6:0] GLYPH_B = 7'h60;
    localparam logic [6:0] GLYPH_C = 7'h31;
    localparam logic [6:0] GLYPH_D = 7'h42;
    localparam logic [6:0] GLYPH_E = 7'h30;
    localparam logic [6:0] GLYPH_F = 7'h38;

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_DWELL = 1'b1
    } scan_phase_t;

endpackage

// File: rtl/multi_digit_led_driver_seg_hex_decoder.sv
// Combinational 4-bit character to active-low seven-segment glyph decoder.
module seg_hex_decoder
    import multi_digit_led_driver_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (hex)
            4'h0: seg = GLYPH_0;
            4'h1: seg = GLYPH_1;
            4'h2: seg = GLYPH_2;
            4'h3: seg = GLYPH_3;
            4'h4: seg = GLYPH_4;
            4'h5: seg = GLYPH_5;
            4'h6: seg = GLYPH_6;
            4'h7: seg = GLYPH_7;
            4'h8: seg = GLYPH_8;
            4'h9: seg = GLYPH_9;
            4'hA: seg = GLYPH_A;
            4'hB: seg = GLYPH_B;
            4'hC: seg = GLYPH_C;
            4'hD: seg = GLYPH_D;
            4'hE: seg = GLYPH_E;
            4'hF: seg = GLYPH_F;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/multi_digit_led_driver.sv
// Multiplexed hex LED driver with double-buffered message load.
// Optional scrolling is enabled by defining LED_DRIVER_SCROLL_EN.
module multi_digit_led_driver
    import multi_digit_led_driver_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int DWELL_CYCLES  = 4,
    parameter int BLANK_CYCLES  = 1,
    parameter int MSG_LEN       = 8,
    parameter int SCROLL_FRAMES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [4*MSG_LEN-1:0]   msg_data,
    input  logic                   msg_valid,
    output logic                   msg_ready,
    output logic [NUM_DIGITS-1:0]  an,
    output logic [6:0]             seg,
    output logic                   frame_tick
);

    localparam int CNT_MAX = (BLANK_CYCLES > DWELL_CYCLES) ? BLANK_CYCLES : DWELL_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int SLOT_W  = $clog2(NUM_DIGITS);
    localparam int IDX_W   = $clog2(MSG_LEN);

    localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(NUM_DIGITS - 1);

    scan_phase_t         phase_q, phase_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;

    logic                ft;
    logic                xfer;
    logic                commit;
    logic                pend_full_q;
    logic [4*MSG_LEN-1:0] pend_q, act_q, act_nxt;
    logic [IDX_W-1:0]    scroll_nxt;
    logic [IDX_W-1:0]    char_idx;
    logic [3:0]          cur_char;
    logic [6:0]          glyph;
    logic [6:0]          seg_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= PH_BLANK;
            cnt_q   <= '0;
            slot_q  <= '0;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        if (enable) begin
            case (phase_q)
                PH_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        phase_d = PH_DWELL;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                PH_DWELL: begin
                    if (cnt_q == DWELL_LAST) begin
                        phase_d = PH_BLANK;
                        cnt_d   = '0;
                        slot_d  = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: phase_d = PH_BLANK;
            endcase
        end
    end

    // Handshake: msg_valid/msg_ready transfer on a rising clk edge when both
    // are high; msg_ready stays low while the pending buffer holds a message.
    assign ft         = enable && (phase_q == PH_BLANK) && (cnt_q == '0) && (slot_q == '0);
    assign frame_tick = reset && ft;
    assign msg_ready  = !pend_full_q;
    assign xfer       = msg_valid && msg_ready;
    assign commit     = ft && pend_full_q;
    assign act_nxt    = commit ? pend_q : act_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_full_q <= 1'b0;
            pend_q      <= '0;
            act_q       <= '0;
        end else if (commit) begin
            act_q       <= pend_q;
            pend_full_q <= 1'b0;
        end else if (xfer) begin
            pend_q      <= msg_data;
            pend_full_q <= 1'b1;
        end
    end

`ifdef LED_DRIVER_SCROLL_EN
    localparam int FC_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
    localparam logic [FC_W-1:0]  FC_LAST     = FC_W'(SCROLL_FRAMES - 1);
    localparam logic [IDX_W-1:0] SCROLL_LAST = IDX_W'(MSG_LEN - 1);

    logic [FC_W-1:0]  fcnt_q, fcnt_d;
    logic [IDX_W-1:0] scroll_q, scroll_d;

    always_comb begin
        fcnt_d   = fcnt_q;
        scroll_d = scroll_q;
        if (commit) begin
            fcnt_d   = '0;
            scroll_d = '0;
        end else if (ft) begin
            if (fcnt_q == FC_LAST) begin
                fcnt_d   = '0;
                scroll_d = (scroll_q == SCROLL_LAST) ? '0 : scroll_q + 1'b1;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fcnt_q   <= '0;
            scroll_q <= '0;
        end else begin
            fcnt_q   <= fcnt_d;
            scroll_q <= scroll_d;
        end
    end

    assign scroll_nxt = scroll_d;
`else
    logic [31:0] scroll_frames_unused;
    assign scroll_frames_unused = 32'(SCROLL_FRAMES);
    assign scroll_nxt = '0;
`endif

    // Glyph for the frame-start slot must already reflect a commit or scroll
    // step taken on the same edge, hence the *_nxt views.
    always_comb begin
        char_idx = IDX_W'((int'(scroll_nxt) + int'(slot_q)) % MSG_LEN);
        cur_char = act_nxt[4*char_idx +: 4];
    end

    seg_hex_decoder u_dec (
        .hex (cur_char),
        .seg (glyph)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_q <= SEG_BLANK;
        end else if (enable && (phase_q == PH_BLANK)) begin
            seg_q <= glyph;
        end
    end

    assign seg = enable ? seg_q : SEG_BLANK;

    always_comb begin
        an = AN_ALL_OFF[NUM_DIGITS-1:0];
        if (enable && (phase_q == PH_DWELL)) begin
            an[SLOT_LAST - slot_q] = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_digit_led_driver.sv
// Bench for multi_digit_led_driver: directed scenarios plus random traffic
// checked every cycle against a frame-position reference model.
module tb_multi_digit_led_driver;

    localparam int N     = 4;
    localparam int D     = 4;
    localparam int B     = 1;
    localparam int L     = 8;
    localparam int SF    = 2;
    localparam int SLOT  = B + D;
    localparam int FRAME = N * SLOT;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           enable = 1'b0;
    logic [4*L-1:0] msg_data = '0;
    logic           msg_valid = 1'b0;
    logic           msg_ready;
    logic [N-1:0]   an;
    logic [6:0]     seg;
    logic           frame_tick;

    always #5 clk = ~clk;

    multi_digit_led_driver #(
        .NUM_DIGITS    (N),
        .DWELL_CYCLES  (D),
        .BLANK_CYCLES  (B),
        .MSG_LEN       (L),
        .SCROLL_FRAMES (SF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .msg_data   (msg_data),
        .msg_valid  (msg_valid),
        .msg_ready  (msg_ready),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    int checks = 0;
    int errors = 0;

    // Active-low a..g patterns for hex digits 0..F.
    logic [6:0] glyph_tab [16] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                   7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    // Reference model: position within the frame counted in enabled cycles,
    // the displayed buffer, scroll offset, and the pending-message queue.
    int             pos;
    int             scroll;
    int             fcnt;
    logic [3:0]     active [L];
    logic [4*L-1:0] exp_q [$];
    bit             last_xfer;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] exp_an();
        logic [3:0] a = 4'hF;
        if (enable && (pos % SLOT) >= B) a[N-1-(pos/SLOT)] = 1'b0;
        return a;
    endfunction

    function automatic logic [6:0] exp_digit(input int p);
        return glyph_tab[active[(scroll + p) % L]];
    endfunction

    task automatic model_reset();
        pos = 0;
        scroll = 0;
        fcnt = 0;
        for (int i = 0; i < L; i++) active[i] = 4'h0;
        exp_q.delete();
    endtask

    task automatic model_update();
        logic [4*L-1:0] m;
        bit xfer;
        xfer = msg_valid && (exp_q.size() == 0);
        if (enable && pos == 0) begin
            if (exp_q.size() > 0) begin
                m = exp_q.pop_front();
                for (int i = 0; i < L; i++) active[i] = m[4*i +: 4];
                scroll = 0;
                fcnt = 0;
            end else begin
`ifdef LED_DRIVER_SCROLL_EN
                if (fcnt == SF - 1) begin
                    fcnt = 0;
                    scroll = (scroll + 1) % L;
                end else begin
                    fcnt++;
                end
`endif
            end
        end
        if (xfer) exp_q.push_back(msg_data);
        last_xfer = xfer;
        if (enable) pos = (pos + 1) % FRAME;
    endtask

    // One clock cycle with inputs already applied; called just after a negedge.
    task automatic cyc();
        #1;
        check("frame_tick", 32'(frame_tick), 32'(enable && pos == 0));
        check("an", 32'(an), 32'(exp_an()));
        check("msg_ready", 32'(msg_ready), 32'(exp_q.size() == 0));
        if (!enable) check("seg_off", 32'(seg), 32'h7F);
        else if ((pos % SLOT) >= B) check("seg_dwell", 32'(seg), 32'(exp_digit(pos / SLOT)));
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic reset_cyc();
        #1;
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_tick", 32'(frame_tick), 32'h0);
        check("rst_ready", 32'(msg_ready), 32'h1);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_to(input int target);
        int n = 0;
        while (pos != target && n <= FRAME) begin
            cyc();
            n++;
        end
        check("run_to_reached", 32'(pos), 32'(target));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        // Reset with enable high
        enable = 1'b1;
        model_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) reset_cyc();
        reset = 1'b1;

        // 1: free-running scan after release
        run(2 * FRAME);

        // 2: load 1,2,3,4 and read digits left to right after the commit
        msg_data = 32'h0000_4321;
        msg_valid = 1'b1;
        cyc();
        msg_valid = 1'b0;
        run_to(0);
        cyc();
        for (int p = 0; p < N; p++) begin
            run_to(p * SLOT + 2);
            check("s2_digit", 32'(seg), 32'(glyph_tab[p + 1]));
        end

        // 3: second offer while pending is full waits until after commit
        msg_data = 32'h89AB_CDEF;
        msg_valid = 1'b1;
        cyc();
        msg_data = 32'h1357_9BDF;
        begin
            int n = 0;
            last_xfer = 1'b0;
            while (!last_xfer && n < 2 * FRAME) begin
                cyc();
                n++;
            end
            check("s3_second_taken", 32'(last_xfer), 32'h1);
        end
        msg_valid = 1'b0;
        run(FRAME);

        // 4: transfer coincident with frame_tick is held one frame
        run_to(0);
        msg_data = 32'hFEDC_BA98;
        msg_valid = 1'b1;
        cyc();
        msg_valid = 1'b0;
        check("s4_held", 32'(exp_q.size()), 32'h1);
        run(2 * FRAME);

        // 5: enable low mid-dwell then resume
        run_to(SLOT + 2);
        enable = 1'b0;
        run(7);
        enable = 1'b1;
        run(2 * FRAME);

        // Random traffic with enable gaps
        for (int i = 0; i < 400; i++) begin
            enable = ($urandom_range(0, 9) != 0);
            msg_valid = ($urandom_range(0, 3) == 0);
            msg_data = {$urandom};
            cyc();
        end

        // Reset mid-handshake discards the pending message
        enable = 1'b1;
        run_to(7);
        msg_data = {$urandom};
        msg_valid = 1'b1;
        cyc();
        msg_valid = 1'b0;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 2; i++) reset_cyc();
        reset = 1'b1;
        run(2 * FRAME);

        for (int i = 0; i < 300; i++) begin
            enable = ($urandom_range(0, 7) != 0);
            msg_valid = ($urandom_range(0, 5) == 0);
            msg_data = {$urandom};
            cyc();
        end

`ifdef LED_DRIVER_SCROLL_EN
        // 6: scrolling message 0..7, leftmost digit advances every SF frames
        enable = 1'b1;
        msg_valid = 1'b0;
        run(FRAME);
        msg_data = 32'h7654_3210;
        msg_valid = 1'b1;
        cyc();
        msg_valid = 1'b0;
        run_to(0);
        for (int f = 0; f < 2 * L * SF; f++) begin
            cyc();
            run_to(2);
            check("s6_leftmost", 32'(seg), 32'(glyph_tab[(f / SF) % L]));
            run_to(0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
